pcie_lane_os_sched: RTL and testbench

Per-lane transmit ordered-set scheduler for the pcieVHost PHY model. It shares one 8-bit lane symbol slot between five sources: the data path, SKP insertion, TS1/TS2 training, FTS and EIOS. It emits pre-scrambler/pre-8b10b symbols plus a control flag. The display lane decodes its output.

---
 rtl/pcie_os_pkg.sv | 45 ++++
 rtl/pcie_skp_timer.sv | 37 +++
 rtl/pcie_lane_os_sched.sv | 178 +++++++++++++++++
 tb/tb_pcie_lane_os_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_os_pkg.sv
// Shared symbols, field offsets and state encoding for the
// per-lane transmit ordered-set scheduler.
package pcie_os_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] FTS    = 8'h3C;
    localparam logic [7:0] IDL    = 8'h7C;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [7:0] LIDLE  = 8'h00;

    localparam int LINKNUM     = 1;
    localparam int LANENUM     = 2;
    localparam int NFTS        = 3;
    localparam int DATARATE    = 4;
    localparam int LINKCONTROL = 5;

    localparam int TS_LEN   = 16;
    localparam int FTS_LEN  = 4;
    localparam int EIOS_LEN = 4;

    typedef enum logic [2:0] {
        DATA,
        OS_TS,
        OS_SKP,
        OS_FTS,
        OS_EIOS
    } osState_t;

    typedef struct packed {
        logic       ts2;
        logic [7:0] linkNum;
        logic [7:0] laneNum;
        logic [7:0] nFts;
        logic [7:0] dataRate;
        logic [7:0] linkCtrl;
    } tsFields_t;

    function automatic logic [7:0] tsId(input logic ts2);
        return ts2 ? TS2_ID : TS1_ID;
    endfunction

endpackage

// File: rtl/pcie_skp_timer.sv
// SKP interval counter: saturates at the interval end and
// raises SkpPending until the SKP ordered set starts.
module pcie_skp_timer
    import pcie_os_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic Clk,
    input  logic notReset,
    input  logic Enable,
    input  logic SkpStart,
    output logic SkpPending
);

    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (!notReset) begin
            count      <= '0;
            SkpPending <= 1'b0;
        end else if (Enable) begin
            if (SkpStart) begin
                count      <= '0;
                SkpPending <= 1'b0;
            end else if (count != LAST) begin
                count <= count + 1'b1;
                if (count == LAST - 1'b1) begin
                    SkpPending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pcie_lane_os_sched.sv
// Per-lane transmit scheduler sharing one symbol slot between
// data, SKP, TS1/TS2, FTS and EIOS sources.
module pcie_lane_os_sched
    import pcie_os_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3
) (
    input  logic       Clk,
    input  logic       notReset,
    input  logic       Enable,
    input  logic       DataBusy,
    input  logic       DataValid,
    input  logic [7:0] DataByte,
    input  logic       DataControl,
    output logic       DataReady,
    input  logic       TsReq,
    input  logic       TsType,
    input  logic [7:0] TsLinkNum,
    input  logic [7:0] TsLaneNum,
    input  logic [7:0] TsNFts,
    input  logic [7:0] TsDataRate,
    input  logic [7:0] TsLinkCtrl,
    input  logic       FtsReq,
    input  logic       EioReq,
    output logic       TsGnt,
    output logic       FtsGnt,
    output logic       EioGnt,
    output logic [7:0] TxByte,
    output logic       TxControl,
    output logic       TxOsActive,
    output logic       SkpPending
);

    localparam logic [3:0] TS_LAST   = 4'(TS_LEN - 1);
    localparam logic [3:0] SKP_LAST  = 4'(SKP_LEN);
    localparam logic [3:0] FTS_LAST  = 4'(FTS_LEN - 1);
    localparam logic [3:0] EIOS_LAST = 4'(EIOS_LEN - 1);

    osState_t   state, stateNext;
    logic [3:0] symIdx, symIdxNext;
    tsFields_t  ts;
    logic [7:0] byteNext;
    logic       ctrlNext, actNext;
    logic       arb, osStart;
    logic       startEio, startSkp, startTs, startFts;

    pcie_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) uSkpTimer (
        .Clk       (Clk),
        .notReset  (notReset),
        .Enable    (Enable),
        .SkpStart  (startSkp),
        .SkpPending(SkpPending)
    );

    always_comb begin
        arb      = (state == DATA) && Enable && !DataBusy;
        startEio = arb && EioReq;
        startSkp = arb && !EioReq && SkpPending;
        startTs  = arb && !EioReq && !SkpPending && TsReq;
        startFts = arb && !EioReq && !SkpPending && !TsReq && FtsReq;
        osStart  = startEio || startSkp || startTs || startFts;
        DataReady = notReset && (state == DATA) && Enable && !osStart;
    end

    // symIdx names the symbol driven onto TxByte at the next edge
    always_comb begin
        stateNext  = state;
        symIdxNext = symIdx + 4'd1;
        byteNext   = LIDLE;
        ctrlNext   = 1'b0;
        actNext    = 1'b1;
        unique case (state)
            DATA: begin
                actNext    = 1'b0;
                symIdxNext = '0;
                if (osStart) begin
                    byteNext   = COM;
                    ctrlNext   = 1'b1;
                    actNext    = 1'b1;
                    symIdxNext = 4'd1;
                    unique case (1'b1)
                        startEio: stateNext = OS_EIOS;
                        startSkp: stateNext = OS_SKP;
                        startTs:  stateNext = OS_TS;
                        startFts: stateNext = OS_FTS;
                    endcase
                end else if (DataValid && DataReady) begin
                    byteNext = DataByte;
                    ctrlNext = DataControl;
                end
            end
            OS_TS: begin
                case (symIdx)
                    4'(LINKNUM): begin
                        byteNext = ts.linkNum;
                        ctrlNext = (ts.linkNum == PAD);
                    end
                    4'(LANENUM): begin
                        byteNext = ts.laneNum;
                        ctrlNext = (ts.laneNum == PAD);
                    end
                    4'(NFTS):        byteNext = ts.nFts;
                    4'(DATARATE):    byteNext = ts.dataRate;
                    4'(LINKCONTROL): byteNext = ts.linkCtrl;
                    default:         byteNext = tsId(ts.ts2);
                endcase
                if (symIdx == TS_LAST) begin
                    stateNext  = DATA;
                    symIdxNext = '0;
                end
            end
            OS_SKP: begin
                byteNext = SKP;
                ctrlNext = 1'b1;
                if (symIdx == SKP_LAST) begin
                    stateNext  = DATA;
                    symIdxNext = '0;
                end
            end
            OS_FTS: begin
                byteNext = FTS;
                ctrlNext = 1'b1;
                if (symIdx == FTS_LAST) begin
                    stateNext  = DATA;
                    symIdxNext = '0;
                end
            end
            OS_EIOS: begin
                byteNext = IDL;
                ctrlNext = 1'b1;
                if (symIdx == EIOS_LAST) begin
                    stateNext  = DATA;
                    symIdxNext = '0;
                end
            end
            default: begin
                stateNext  = DATA;
                symIdxNext = '0;
                actNext    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!notReset) begin
            state      <= DATA;
            symIdx     <= '0;
            TxByte     <= LIDLE;
            TxControl  <= 1'b0;
            TxOsActive <= 1'b0;
            TsGnt      <= 1'b0;
            FtsGnt     <= 1'b0;
            EioGnt     <= 1'b0;
            ts         <= '0;
        end else begin
            state      <= stateNext;
            symIdx     <= symIdxNext;
            TxByte     <= byteNext;
            TxControl  <= ctrlNext;
            TxOsActive <= actNext;
            TsGnt      <= startTs;
            FtsGnt     <= startFts;
            EioGnt     <= startEio;
            if (startTs) begin
                ts <= '{ts2:      TsType,
                        linkNum:  TsLinkNum,
                        laneNum:  TsLaneNum,
                        nFts:     TsNFts,
                        dataRate: TsDataRate,
                        linkCtrl: TsLinkCtrl};
            end
        end
    end

endmodule

// File: tb/tb_pcie_lane_os_sched.sv
// Scoreboard bench for pcie_lane_os_sched with a short
// SKP interval so ordered sets interleave quickly.
module tb_pcie_lane_os_sched;

    logic       Clk = 1'b0;
    logic       notReset, Enable, DataBusy, DataValid, DataControl;
    logic [7:0] DataByte;
    logic       DataReady;
    logic       TsReq, TsType, FtsReq, EioReq;
    logic [7:0] TsLinkNum, TsLaneNum, TsNFts, TsDataRate, TsLinkCtrl;
    logic       TsGnt, FtsGnt, EioGnt;
    logic [7:0] TxByte;
    logic       TxControl, TxOsActive, SkpPending;

    typedef struct packed {
        logic [7:0] b;
        logic       k;
        logic       act;
        logic [2:0] g;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [12:0] got;
    int nChecks = 0;
    int nFail = 0;

    always #5 Clk = ~Clk;

    pcie_lane_os_sched #(
        .SKP_INTERVAL(16),
        .SKP_LEN(3)
    ) dut (
        .Clk(Clk), .notReset(notReset), .Enable(Enable),
        .DataBusy(DataBusy), .DataValid(DataValid),
        .DataByte(DataByte), .DataControl(DataControl),
        .DataReady(DataReady), .TsReq(TsReq), .TsType(TsType),
        .TsLinkNum(TsLinkNum), .TsLaneNum(TsLaneNum),
        .TsNFts(TsNFts), .TsDataRate(TsDataRate),
        .TsLinkCtrl(TsLinkCtrl), .FtsReq(FtsReq), .EioReq(EioReq),
        .TsGnt(TsGnt), .FtsGnt(FtsGnt), .EioGnt(EioGnt),
        .TxByte(TxByte), .TxControl(TxControl),
        .TxOsActive(TxOsActive), .SkpPending(SkpPending)
    );

    function automatic void push(input logic [7:0] b, input logic k,
                                 input logic act, input logic [2:0] g);
        exp_t x;
        x.b = b; x.k = k; x.act = act; x.g = g;
        sb.push_back(x);
    endfunction

    function automatic void pushIdle(input int n);
        for (int i = 0; i < n; i++) push(8'h00, 1'b0, 1'b0, 3'b000);
    endfunction

    function automatic void pushKos(input logic [7:0] sym, input logic [2:0] g,
                                    input int n);
        push(8'hBC, 1'b1, 1'b1, g);
        for (int i = 0; i < n; i++) push(sym, 1'b1, 1'b1, 3'b000);
    endfunction

    function automatic void pushTs(input logic t2, input logic [7:0] l,
                                   input logic [7:0] ln, input logic [7:0] nf,
                                   input logic [7:0] dr, input logic [7:0] lc);
        push(8'hBC, 1'b1, 1'b1, 3'b001);
        push(l, l == 8'hF7, 1'b1, 3'b000);
        push(ln, ln == 8'hF7, 1'b1, 3'b000);
        push(nf, 1'b0, 1'b1, 3'b000);
        push(dr, 1'b0, 1'b1, 3'b000);
        push(lc, 1'b0, 1'b1, 3'b000);
        for (int i = 0; i < 10; i++) push(t2 ? 8'h45 : 8'h4A, 1'b0, 1'b1, 3'b000);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic dropGrants();
        if (TsGnt) TsReq = 1'b0;
        if (FtsGnt) FtsReq = 1'b0;
        if (EioGnt) EioReq = 1'b0;
    endtask

    task automatic doReset();
        notReset = 1'b0; Enable = 1'b0; DataBusy = 1'b0;
        DataValid = 1'b0; DataByte = 8'h00; DataControl = 1'b0;
        TsReq = 1'b0; TsType = 1'b0; FtsReq = 1'b0; EioReq = 1'b0;
        TsLinkNum = 8'h00; TsLaneNum = 8'h00; TsNFts = 8'h00;
        TsDataRate = 8'h00; TsLinkCtrl = 8'h00;
        sb.delete();
        tick();
        tick();
        notReset = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        notReset = 1'b0; Enable = 1'b1; TsReq = 1'b1;
        DataValid = 1'b1; DataByte = 8'h55;
        for (int c = 0; c < 3; c++) begin
            tick();
            nChecks++;
            got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
            if (got !== 13'h0) begin
                nFail++;
                $display("FAIL reset_out cyc %0d got %h want 0000", c, got);
            end
            nChecks++;
            if (DataReady !== 1'b0 || SkpPending !== 1'b0) begin
                nFail++;
                $display("FAIL reset_rdy cyc %0d got rdy=%b skp=%b want 0 0",
                         c, DataReady, SkpPending);
            end
        end
    endtask

    task automatic test_idle_skp();
        doReset();
        Enable = 1'b1;
        pushIdle(15); pushKos(8'h1C, 3'b000, 3);
        pushIdle(12); pushKos(8'h1C, 3'b000, 3); pushIdle(1);
        for (int c = 0; c < 36; c++) begin
            if (c == 5 || c == 15) begin
                nChecks++;
                if (DataReady !== (c == 5)) begin
                    nFail++;
                    $display("FAIL idle_rdy cyc %0d got %b want %b", c,
                             DataReady, c == 5);
                end
            end
            tick();
            if (c >= 13 && c <= 15) begin
                nChecks++;
                if (SkpPending !== (c == 14)) begin
                    nFail++;
                    $display("FAIL idle_pend cyc %0d got %b want %b", c,
                             SkpPending, c == 14);
                end
            end
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL idle scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL idle cyc %0d got %h want %h", c, got, e);
                end
            end
            dropGrants();
        end
    endtask

    task automatic test_ts();
        doReset();
        Enable = 1'b1; TsReq = 1'b1; TsType = 1'b1;
        TsLinkNum = 8'h05; TsLaneNum = 8'hF7; TsNFts = 8'h20;
        TsDataRate = 8'h02; TsLinkCtrl = 8'h00;
        pushTs(1'b1, 8'h05, 8'hF7, 8'h20, 8'h02, 8'h00);
        pushKos(8'h1C, 3'b000, 3); pushIdle(2);
        for (int c = 0; c < 22; c++) begin
            tick();
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL ts scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL ts cyc %0d got %h want %h", c, got, e);
                end
            end
            dropGrants();
            if (c == 0) begin
                TsType = 1'b0; TsLinkNum = 8'hAA; TsLaneNum = 8'hBB;
                TsNFts = 8'hCC; TsDataRate = 8'hDD; TsLinkCtrl = 8'hEE;
            end
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        Enable = 1'b1; EioReq = 1'b1; TsReq = 1'b1; FtsReq = 1'b1;
        TsType = 1'b0; TsLinkNum = 8'hF7; TsLaneNum = 8'h01;
        TsNFts = 8'hFF; TsDataRate = 8'h04; TsLinkCtrl = 8'h01;
        pushKos(8'h7C, 3'b100, 3);
        pushTs(1'b0, 8'hF7, 8'h01, 8'hFF, 8'h04, 8'h01);
        pushKos(8'h1C, 3'b000, 3);
        pushKos(8'h3C, 3'b010, 3);
        pushIdle(2);
        for (int c = 0; c < 30; c++) begin
            tick();
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL b2b scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL b2b cyc %0d got %h want %h", c, got, e);
                end
            end
            dropGrants();
        end
    endtask

    task automatic test_busy();
        doReset();
        Enable = 1'b1; DataBusy = 1'b1; DataValid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            DataByte = 8'(c * 7 + 3);
            DataControl = (c % 3 == 0);
            push(DataByte, DataControl, 1'b0, 3'b000);
            #1;
            nChecks++;
            if (DataReady !== 1'b1) begin
                nFail++;
                $display("FAIL busy_rdy cyc %0d got %b want 1", c, DataReady);
            end
            tick();
            nChecks++;
            e = sb.pop_front();
            got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
            if (got !== e || (c >= 14 && SkpPending !== 1'b1)) begin
                nFail++;
                $display("FAIL busy cyc %0d got %h pend %b want %h", c, got,
                         SkpPending, e);
            end
        end
        DataBusy = 1'b0; DataByte = 8'hEE;
        #1;
        nChecks++;
        if (DataReady !== 1'b0) begin
            nFail++;
            $display("FAIL busy_fall_rdy got %b want 0", DataReady);
        end
        pushKos(8'h1C, 3'b000, 3); pushIdle(12); pushKos(8'h1C, 3'b000, 3);
        for (int c = 0; c < 20; c++) begin
            tick();
            DataValid = 1'b0;
            if (c == 0) begin
                nChecks++;
                if (SkpPending !== 1'b0) begin
                    nFail++;
                    $display("FAIL busy_pend_clr got %b want 0", SkpPending);
                end
            end
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL busy scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL busy_skp cyc %0d got %h want %h", c, got, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_os();
        doReset();
        Enable = 1'b1; TsReq = 1'b1; TsType = 1'b0;
        TsLinkNum = 8'h11; TsLaneNum = 8'h22; TsNFts = 8'h33;
        TsDataRate = 8'h44; TsLinkCtrl = 8'h55;
        pushTs(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        for (int c = 0; c < 8; c++) begin
            tick();
            nChecks++;
            e = sb.pop_front();
            got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
            if (got !== e) begin
                nFail++;
                $display("FAIL rst_mid cyc %0d got %h want %h", c, got, e);
            end
            dropGrants();
        end
        sb.delete();
        notReset = 1'b0;
        tick();
        nChecks++;
        got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
        if (got !== 13'h0 || SkpPending !== 1'b0) begin
            nFail++;
            $display("FAIL rst_mid_abort got %h pend %b want 0000 0", got,
                     SkpPending);
        end
        notReset = 1'b1;
        #1;
        nChecks++;
        if (DataReady !== 1'b1) begin
            nFail++;
            $display("FAIL rst_mid_state got rdy %b want 1", DataReady);
        end
        pushIdle(15); pushKos(8'h1C, 3'b000, 3); pushIdle(1);
        for (int c = 0; c < 20; c++) begin
            tick();
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL rst_mid scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL rst_mid_after cyc %0d got %h want %h", c, got, e);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        doReset();
        Enable = 1'b1;
        pushIdle(15); pushKos(8'h1C, 3'b000, 3); pushIdle(5);
        pushKos(8'h3C, 3'b010, 3); pushIdle(9);
        pushKos(8'h1C, 3'b000, 3); pushIdle(1);
        for (int c = 0; c < 42; c++) begin
            tick();
            nChecks++;
            if (sb.size() == 0) begin
                nFail++;
                $display("FAIL en_drop scoreboard empty cyc %0d", c);
            end else begin
                e = sb.pop_front();
                got = {TxByte, TxControl, TxOsActive, EioGnt, FtsGnt, TsGnt};
                if (got !== e) begin
                    nFail++;
                    $display("FAIL en_drop cyc %0d got %h want %h", c, got, e);
                end
            end
            dropGrants();
            if (c == 17) begin
                Enable = 1'b0; FtsReq = 1'b1;
                DataValid = 1'b1; DataByte = 8'hAA;
            end
            if (c == 20) begin
                nChecks++;
                if (DataReady !== 1'b0) begin
                    nFail++;
                    $display("FAIL en_drop_rdy got %b want 0", DataReady);
                end
            end
            if (c == 23) begin
                Enable = 1'b1; DataValid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_skp();
        test_ts();
        test_back_to_back();
        test_busy();
        test_reset_mid_os();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
